// File: rtl/match_run_logger.sv
// match_run_logger: measures runs of consecutive det_in=1 samples and queues completed run lengths in a show-ahead FIFO.
module match_run_logger #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_in,
    input  logic             clr,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [LEN_W-1:0] rd_len,
    output logic [CNT_W-1:0] run_count,
    output logic             run_active,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] mem [DEPTH];
    logic             push, pop, full, wr_en;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        push    = 1'b0;
        if (clr) begin
            state_d = IDLE;
            len_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = det_in ? RUN : IDLE;
            len_d   = det_in ? LEN_W'(1) : len_q;
        end else if (det_in) begin
            len_d = &len_q ? len_q : len_q + LEN_W'(1);
        end else begin
            state_d = IDLE;
            len_d   = '0;
            push    = 1'b1;
        end
    end

    // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
    assign rd_valid   = wr_q != rd_q;
    assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop        = rd_valid && rd_ready && !clr;
    assign wr_en      = push && (!full || pop);
    assign wr_d       = clr ? '0 : wr_q + (AW+1)'(wr_en);
    assign rd_d       = clr ? '0 : rd_q + (AW+1)'(pop);
    assign cnt_d      = clr ? '0 : cnt_q + CNT_W'(push && !(&cnt_q));
    assign ovf_d      = !clr && (ovf_q || (push && !wr_en));
    assign rd_len     = rd_valid ? mem[rd_q[AW-1:0]] : '0;
    assign run_count  = cnt_q;
    assign run_active = state_q == RUN;
    assign overflow   = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= len_q;
    end
endmodule

// File: tb/tb_match_run_logger.sv
// tb_match_run_logger: directed scenarios plus random traffic checked against a queue-based run-length model.
module tb_match_run_logger;
    localparam int DEPTH = 4;
    localparam int LMAX = 255;
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        det_in = 1'b0;
    logic        clr = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [7:0]  rd_len;
    logic [15:0] run_count;
    logic        run_active;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int mq[$];
    int m_len, m_cnt;
    bit m_act, m_ovf;

    match_run_logger #(.DEPTH(DEPTH), .LEN_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .det_in(det_in), .clr(clr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_len(rd_len), .run_count(run_count),
        .run_active(run_active), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_len = 0;
        m_cnt = 0;
        m_act = 0;
        m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ":valid"}, int'(rd_valid), int'(mq.size() > 0));
        if (mq.size() > 0) check({tag, ":len"}, int'(rd_len), mq[0]);
        check({tag, ":count"}, int'(run_count), m_cnt);
        check({tag, ":active"}, int'(run_active), int'(m_act));
        check({tag, ":ovf"}, int'(overflow), int'(m_ovf));
    endtask

    // One clock edge with the given inputs; the model advances from its pre-edge view.
    task automatic step(input logic d, input logic r, input logic c, input string tag);
        int pre;
        bit do_pop;
        det_in = d;
        rd_ready = r;
        clr = c;
        @(posedge clk);
        if (c) model_clear();
        else begin
            pre = mq.size();
            do_pop = pre > 0 && r;
            if (do_pop) void'(mq.pop_front());
            if (m_act && !d) begin
                if (pre < DEPTH || do_pop) mq.push_back(m_len);
                else m_ovf = 1;
                if (m_cnt < CMAX) m_cnt++;
                m_act = 0;
                m_len = 0;
            end else if (d) begin
                m_len = m_act ? (m_len < LMAX ? m_len + 1 : LMAX) : 1;
                m_act = 1;
            end
        end
        #1;
        clr = 1'b0;
        check_all(tag);
    endtask

    task automatic run(input int n, input logic r, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, r, 1'b0, tag);
        step(1'b0, r, 1'b0, tag);
    endtask

    initial begin
        model_clear();
        #3;
        check("rst_valid", int'(rd_valid), 0);
        check("rst_count", int'(run_count), 0);
        check("rst_active", int'(run_active), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, "s1_run");
            check("s1_active", int'(run_active), 1);
        end
        step(1'b0, 1'b0, 1'b0, "s1_end");
        check("s1_valid", int'(rd_valid), 1);
        check("s1_len", int'(rd_len), 3);
        check("s1_count", int'(run_count), 1);

        step(1'b0, 1'b0, 1'b1, "s2_clr");
        run(300, 1'b0, "s2_run");
        check("s2_len", int'(rd_len), 255);
        check("s2_count", int'(run_count), 1);

        step(1'b0, 1'b0, 1'b1, "s3_clr");
        for (int l = 1; l <= 5; l++) run(l, 1'b0, "s3_run");
        check("s3_ovf", int'(overflow), 1);
        check("s3_count", int'(run_count), 5);
        for (int l = 1; l <= 4; l++) begin
            check("s3_drain", int'(rd_len), l);
            step(1'b0, 1'b1, 1'b0, "s3_pop");
        end
        check("s3_empty", int'(rd_valid), 0);

        step(1'b0, 1'b0, 1'b1, "s4_clr");
        for (int l = 1; l <= 4; l++) run(l, 1'b0, "s4_fill");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "s4_run");
        step(1'b0, 1'b1, 1'b0, "s4_pushpop");
        check("s4_head", int'(rd_len), 2);
        check("s4_ovf", int'(overflow), 0);
        for (int l = 2; l <= 5; l++) begin
            check("s4_drain", int'(rd_len), l);
            step(1'b0, 1'b1, 1'b0, "s4_pop");
        end
        check("s4_empty", int'(rd_valid), 0);

        step(1'b0, 1'b0, 1'b1, "s5_clr");
        run(1, 1'b0, "s5_q");
        run(2, 1'b0, "s5_q");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, "s5_run");
        #1 reset = 1'b1;
        #1;
        model_clear();
        check("s5_valid", int'(rd_valid), 0);
        check("s5_len", int'(rd_len), 0);
        check("s5_count", int'(run_count), 0);
        check("s5_active", int'(run_active), 0);
        check("s5_ovf", int'(overflow), 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "s5_idle");
        run(2, 1'b0, "s5_new");
        check("s5_newlen", int'(rd_len), 2);

        step(1'b0, 1'b0, 1'b1, "s6_clr");
        for (int i = 0; i < 7; i++) run(1, 1'b0, "s6_fill");
        step(1'b0, 1'b1, 1'b0, "s6_pop");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, "s6_run");
        check("s6_pre_count", int'(run_count), 7);
        check("s6_pre_ovf", int'(overflow), 1);
        step(1'b1, 1'b0, 1'b1, "s6_clr_det");
        check("s6_valid", int'(rd_valid), 0);
        check("s6_count", int'(run_count), 0);
        check("s6_ovf", int'(overflow), 0);
        run(3, 1'b0, "s6_new");
        check("s6_newlen", int'(rd_len), 3);

        step(1'b0, 1'b0, 1'b1, "rnd_clr");
        for (int i = 0; i < 1500; i++)
            step(1'(($urandom % 10) < 7), 1'(($urandom % 10) < 3), 1'(($urandom % 128) == 0), "rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/match_run_logger.md
MATCH_RUN_LOGGER -- requirements
Module: match_run_logger

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DEPTH  4   run-length FIFO entries, power of two, >= 2
  LEN_W  8   run-length field width
  CNT_W  16  completed-run counter width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk        input   1      clock, all state updates on rising edge
  reset      input   1      reset, asynchronous, active-high
  det_in     input   1      registered match-detect flag from the upstream equality-sequence detector
  clr        input   1      synchronous clear of FIFO, counter, overflow, FSM
  rd_ready   input   1      consumer accepts head entry
  rd_valid   output  1      FIFO non-empty
  rd_len     output  LEN_W  head entry run length, show-ahead
  run_count  output  CNT_W  completed runs since reset/clr
  run_active output  1      a run is currently being measured
  overflow   output  1      sticky: a completed run was dropped

Function
REQ-003 det_in SHALL be sampled on every rising clk edge; no input synchronizer.
REQ-004 The FSM SHALL have two states, IDLE and RUN; run_active SHALL equal (state == RUN), registered.
REQ-005 IDLE with det_in=1 SHALL go to RUN and load len = 1; IDLE with det_in=0 SHALL stay in IDLE.
REQ-006 RUN with det_in=1 SHALL increment len, saturating at 2^LEN_W-1, no wrap.
REQ-007 RUN with det_in=0 SHALL go to IDLE, push len into the FIFO, and increment run_count, saturating at 2^CNT_W-1.
REQ-008 Run length SHALL equal the number of consecutive edges at which det_in was sampled 1.
REQ-009 A pushed entry SHALL appear on rd_valid/rd_len in the cycle after the push edge: 1-cycle latency from the edge sampling det_in=0.
REQ-010 The FIFO SHALL be first-in first-out; rd_len SHALL present the oldest entry whenever rd_valid=1; rd_len is don't-care when rd_valid=0.
REQ-011 A pop SHALL occur at an edge where rd_valid=1 and rd_ready=1; rd_ready with rd_valid=0 SHALL have no effect.
REQ-012 Push into a full FIFO with a pop at the same edge SHALL perform both; occupancy stays DEPTH, overflow unchanged.
REQ-013 Push into a full FIFO without a pop SHALL discard the new entry and set overflow=1; run_count still increments.
REQ-014 Push and pop at the same edge on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-015 Push into an empty FIFO with rd_ready=1 SHALL NOT bypass: the entry is readable from the next cycle.
REQ-016 overflow SHALL stay 1 until reset or clr.
REQ-017 clr=1 SHALL take priority over all other updates at that edge: FIFO empty, run_count=0, overflow=0, FSM to IDLE, len=0.
REQ-018 A run in progress at clr SHALL be discarded. If det_in=1 at the first edge after clr, a new run SHALL start with len=1.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH. Occupancy SHALL be tracked with one extra bit, or an equivalent scheme, to distinguish full from empty.

Reset
REQ-020 reset=1 SHALL immediately force, without waiting for clk: IDLE, len=0, FIFO empty, rd_valid=0, run_count=0, run_active=0, overflow=0, rd_len=0.
REQ-021 A run in progress at reset SHALL be discarded with no FIFO entry.
REQ-022 After reset deasserts, the first rising edge SHALL evaluate det_in per REQ-005.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - det_in=1 for 3 edges, then 0 -> run_active=1 for 3 cycles; next cycle rd_valid=1, rd_len=3, run_count=1.
  - det_in=1 for 300 edges, then 0 -> rd_len=255 (LEN_W=8), run_count=1.
  - Runs of length 1,2,3,4,5 separated by one low cycle, rd_ready=0 -> overflow=1, run_count=5; draining with rd_ready=1 yields 1,2,3,4, then rd_valid=0.
  - FIFO full (1,2,3,4), rd_ready=1 at the edge pushing length 5 -> head becomes 2, occupancy 4, overflow=0; drain yields 2,3,4,5.
  - reset pulsed at run length 10 with 2 entries queued -> all outputs 0 asynchronously; after release rd_valid=0 until a new run completes.
  - clr with 3 entries, overflow=1, run_count=7, det_in=1 -> next cycle rd_valid=0, run_count=0, overflow=0, run_active=1, measured length counts from 1.
